// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl
//   FSM sequencer for a shift-add sequential multiplier datapath. It loads the
//   multiplier shift register, then runs WIDTH add/shift iterations. Each
//   iteration samples the multiplier LSB (m_bit). It then pulses done for one
//   cycle and returns to IDLE.
//
//   Optional feature: define SEQ_MULT_ABORT_EN to add the abort input. When
//   abort is high in any non-IDLE state, the sequencer returns to IDLE and
//   produces no done pulse.
//
// Ports
//   clk      in   rising-edge clock
//   clr      in   synchronous reset, active-high; outranks every other input
//   start    in   request a multiply; sampled only in IDLE
//   m_bit    in   current multiplier LSB; sampled only in ADD
//   abort    in   (SEQ_MULT_ABORT_EN only) cancel the running operation
//   ld_mplr  out  load multiplier shift register
//   sh_mplr  out  shift multiplier register right by one
//   clr_acc  out  clear accumulator/product register
//   add_acc  out  add multiplicand into accumulator upper half
//   sh_acc   out  shift accumulator right by one
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse; product valid in the accumulator
// -----------------------------------------------------------------------------
module seq_mult_ctrl #(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic clr,
   input  logic start,
   input  logic m_bit,
`ifdef SEQ_MULT_ABORT_EN
   input  logic abort,
`endif
   output logic ld_mplr,
   output logic sh_mplr,
   output logic clr_acc,
   output logic add_acc,
   output logic sh_acc,
   output logic busy,
   output logic done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;

   // NOTE: state is updated with non-blocking assignments only. This way every
   // always_ff block reads the pre-edge values, whatever the evaluation order.
   always_ff @(posedge clk) begin
      if (clr) begin
         state <= S_IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // NOTE: every signal driven here receives a default before the case
   // statement. Otherwise a path that leaves it unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      ld_mplr   = 1'b0;
      sh_mplr   = 1'b0;
      clr_acc   = 1'b0;
      add_acc   = 1'b0;
      sh_acc    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;

      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            ld_mplr   = 1'b1;
            clr_acc   = 1'b1;
            count_nxt = '0;
            state_nxt = S_ADD;
         end
         S_ADD: begin
            // The only Mealy output: the add depends on the live multiplier LSB.
            add_acc   = m_bit;
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            sh_mplr = 1'b1;
            sh_acc  = 1'b1;
            // Leaving at the last iteration keeps count from ever wrapping.
            if (count == LAST_ITER) begin
               state_nxt = S_DONE;
            end else begin
               count_nxt = count + 1'b1;
               state_nxt = S_ADD;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = S_IDLE;
            count_nxt = '0;
         end
      endcase

`ifdef SEQ_MULT_ABORT_EN
      // Abort only cancels a running operation. In IDLE it is ignored, so
      // start still wins there.
      if (abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
         count_nxt = '0;
      end
`endif
   end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_ctrl
//   Self-checking bench for seq_mult_ctrl. The reference model tracks the
//   position within an operation as a cycle number: 0 = idle, 1 = load,
//   2..2W+1 = alternating add/shift, 2W+2 = done. The expected strobes are
//   derived from that number by arithmetic.
// -----------------------------------------------------------------------------
module tb_seq_mult_ctrl;

   localparam int W = 4;
   localparam int LAST = 2 * W + 2;

   logic clk = 1'b0;
   logic clr, start, m_bit, abort;
   logic ld_mplr, sh_mplr, clr_acc, add_acc, sh_acc, busy, done;

   always #5 clk = ~clk;

   seq_mult_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .m_bit   (m_bit),
`ifdef SEQ_MULT_ABORT_EN
      .abort   (abort),
`endif
      .ld_mplr (ld_mplr),
      .sh_mplr (sh_mplr),
      .clr_acc (clr_acc),
      .add_acc (add_acc),
      .sh_acc  (sh_acc),
      .busy    (busy),
      .done    (done)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          ph       = 0;  // model position within the operation
   int          cyc      = 0;
   int          done_cnt = 0;
   logic [31:0] mplr     = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Expected {ld_mplr, sh_mplr, clr_acc, add_acc, sh_acc, busy, done}.
   function automatic logic [6:0] model_outs(input int p, input logic mb);
      logic ld, ad, sh, bz, dn;
      ld = (p == 1);
      ad = (p >= 2) && (p <= 2 * W) && (p % 2 == 0) && mb;
      sh = (p >= 3) && (p <= 2 * W + 1) && (p % 2 == 1);
      bz = (p != 0);
      dn = (p == LAST);
      return {ld, sh, ld, ad, sh, bz, dn};
   endfunction

   // One clock cycle: drive inputs, check outputs mid-cycle, then advance the
   // model across the rising edge.
   task automatic cycle(input logic s, input logic c, input logic a);
      @(negedge clk);
      start = s;
      clr   = c;
      abort = a;
      if ((ph >= 2) && (ph <= 2 * W) && (ph % 2 == 0))
         m_bit = mplr[(ph - 2) / 2];
      else
         m_bit = 1'($urandom);
      #1;
      check("outs", {25'd0, ld_mplr, sh_mplr, clr_acc, add_acc, sh_acc, busy, done},
            {25'd0, model_outs(ph, m_bit)});
      if (done) done_cnt++;
      @(posedge clk);
      cyc++;
      if (c)                            ph = 0;
`ifdef SEQ_MULT_ABORT_EN
      else if (a && ph != 0)            ph = 0;
`endif
      else if (ph == 0)                 ph = s ? 1 : 0;
      else if (ph == LAST)              ph = 0;
      else                              ph = ph + 1;
   endtask

   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      clr   = 1'b1;
      start = 1'b0;
      m_bit = 1'b0;
      abort = 1'b0;
      @(posedge clk);

      // Reset held: everything low.
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      run_idle(2);

      // Multiplier 1011: adds in cycles 2, 4 and 8, done in cycle 10.
      mplr = 32'hB;
      done_cnt = 0;
      cycle(1'b1, 1'b0, 1'b0);
      run_idle(LAST + 1);
      check("done_1011", done_cnt, 1);

      // Multiplier 0000: no adds, done still produced.
      mplr = 32'h0;
      done_cnt = 0;
      cycle(1'b1, 1'b0, 1'b0);
      run_idle(LAST + 1);
      check("done_0000", done_cnt, 1);

      // start held high for 25 cycles: two complete operations.
      mplr = 32'h6;
      done_cnt = 0;
      for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0, 1'b0);
      check("held_start_dones", done_cnt, 2);
      run_idle(LAST + 2);

      // clr asserted in cycle 5 of an operation: no done, then a clean replay.
      mplr = 32'hF;
      done_cnt = 0;
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      run_idle(LAST);
      check("clr_no_done", done_cnt, 0);
      cycle(1'b1, 1'b0, 1'b0);
      run_idle(LAST + 1);
      check("replay_done", done_cnt, 1);

`ifdef SEQ_MULT_ABORT_EN
      // abort asserted in cycle 4: IDLE in cycle 5 and no done.
      done_cnt = 0;
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      run_idle(LAST);
      check("abort_no_done", done_cnt, 0);
      // abort together with start in IDLE: the operation runs normally.
      cycle(1'b1, 1'b0, 1'b1);
      run_idle(LAST + 1);
      check("abort_idle_done", done_cnt, 1);
`endif

      // Randomized traffic with occasional clr (and abort when present).
      for (int i = 0; i < 600; i++) begin
         logic s, c, a;
         if (ph == 0) mplr = $urandom;
         s = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 60) == 0);
`ifdef SEQ_MULT_ABORT_EN
         a = ($urandom_range(0, 40) == 0);
`else
         a = 1'($urandom);  // no abort port: must have no effect
`endif
         cycle(s, c, a);
      end
      run_idle(LAST + 2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
